// File: rtl/seg7_scan_gate.sv
// Multiplexed 7-segment scan driver with display-enable gate, per-digit blanking and
// frame-coherent snapshots. Define BLINK_EN to add per-digit blinking from blink_mask.
module seg7_scan_gate #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned SCAN_DIV   = 1000,
    parameter bit          SEG_ACT    = 1'b1,
    parameter bit          COM_ACT    = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   com,
    output logic                    frame_done
);

    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PRESC_W = $clog2(SCAN_DIV);

    localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF    = {7{~SEG_ACT}};
    localparam logic                  DP_OFF     = ~SEG_ACT;
    localparam logic [NUM_DIGITS-1:0] COM_OFF    = {NUM_DIGITS{~COM_ACT}};

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        s = 7'h00;
        case (h)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic                    en_q, en_d;
    logic [PRESC_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] digits_s_q, digits_s_d;
    logic [NUM_DIGITS-1:0]   blank_s_q, blank_s_d;
    logic [NUM_DIGITS-1:0]   dp_s_q, dp_s_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   com_q, com_d;
    logic                    frame_done_q, frame_done_d;

    logic first_cyc;
    logic scanning;
    logic wrap;
    logic snap;
    logic blink_dark;

    // The cycle en is first seen high restarts the scan; outputs follow one cycle later.
    assign first_cyc = en && !en_q;
    assign scanning  = en && en_q;
    assign wrap      = scanning && (presc_q == PRESC_LAST) && (idx_q == IDX_LAST);
    assign snap      = first_cyc || wrap;

`ifdef BLINK_EN
    localparam int unsigned BLINK_SHIFT = 5;

    logic [BLINK_SHIFT:0]  blink_cnt_q, blink_cnt_d;
    logic [NUM_DIGITS-1:0] blink_s_q, blink_s_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_s_d   = blink_s_q;
        if (!en) begin
            blink_cnt_d = '0;
        end else if (wrap) begin
            blink_cnt_d = blink_cnt_q + (BLINK_SHIFT+1)'(1);
        end
        if (snap) begin
            blink_s_d = blink_mask;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_q <= '0;
            blink_s_q   <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_s_q   <= blink_s_d;
        end
    end

    assign blink_dark = blink_cnt_q[BLINK_SHIFT] & blink_s_q[idx_q];
`else
    logic blink_unused;
    assign blink_unused = ^blink_mask;
    assign blink_dark   = 1'b0;
`endif

    always_comb begin
        logic [6:0]            seg_raw;
        logic                  dp_raw;
        logic [NUM_DIGITS-1:0] com_raw;
        // NOTE: every combinational output gets a default first so no path infers a latch.
        en_d         = en;
        presc_d      = presc_q;
        idx_d        = idx_q;
        digits_s_d   = digits_s_q;
        blank_s_d    = blank_s_q;
        dp_s_d       = dp_s_q;
        frame_done_d = wrap;
        seg_raw      = 7'h00;
        dp_raw       = 1'b0;
        com_raw      = '0;

        if (!scanning) begin
            presc_d = '0;
            idx_d   = '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            presc_d = presc_q + PRESC_W'(1);
        end

        if (snap) begin
            digits_s_d = digits;
            blank_s_d  = blank_mask;
            dp_s_d     = dp_mask;
        end

        // Blanked digits keep their com slot so scan timing never shifts.
        if (scanning) begin
            com_raw[idx_q] = 1'b1;
            if (!(blank_s_q[idx_q] || blink_dark)) begin
                seg_raw = hex_to_seg(digits_s_q[{idx_q, 2'b00} +: 4]);
                dp_raw  = dp_s_q[idx_q];
            end
        end

        seg_d = seg_raw ^ SEG_OFF;
        dp_d  = dp_raw ^ DP_OFF;
        com_d = com_raw ^ COM_OFF;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q         <= 1'b0;
            presc_q      <= '0;
            idx_q        <= '0;
            digits_s_q   <= '0;
            blank_s_q    <= '0;
            dp_s_q       <= '0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            com_q        <= COM_OFF;
            frame_done_q <= 1'b0;
        end else begin
            en_q         <= en_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            digits_s_q   <= digits_s_d;
            blank_s_q    <= blank_s_d;
            dp_s_q       <= dp_s_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            com_q        <= com_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign com        = com_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_gate.sv
// Scoreboard bench for seg7_scan_gate (6 digits, 4-cycle slots, active-high seg, active-low com).
// Expected output words are queued as stimulus is applied and compared on the falling edge.
module tb_seg7_scan_gate;

    localparam int ND = 6;

`ifdef BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    localparam logic [14:0] INACT = {7'h00, 1'b0, 6'h3F, 1'b0};

    logic            clk;
    logic            rst;
    logic            en;
    logic [4*ND-1:0] digits;
    logic [ND-1:0]   blank_mask;
    logic [ND-1:0]   dp_mask;
    logic [ND-1:0]   blink_mask;
    logic [6:0]      seg;
    logic            dp;
    logic [ND-1:0]   com;
    logic            frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [14:0] exp_q[$];
    string       tag_q[$];

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg7_scan_gate #(
        .NUM_DIGITS(ND),
        .SCAN_DIV  (4),
        .SEG_ACT   (1'b1),
        .COM_ACT   (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .digits    (digits),
        .blank_mask(blank_mask),
        .dp_mask   (dp_mask),
        .blink_mask(blink_mask),
        .seg       (seg),
        .dp        (dp),
        .com       (com),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got {seg,dp,com,fd}=%h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [14:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, {seg, dp, com, frame_done}, e);
        end
    end

    function automatic logic [14:0] exp_word(input int s, input logic [3:0] h, input bit dark,
                                             input bit dpb, input bit fd);
        logic [5:0] one;
        logic [6:0] sg;
        one = 6'b000001;
        sg  = dark ? 7'h00 : seg_tab[h];
        return {sg, dark ? 1'b0 : dpb, ~(one << s), fd};
    endfunction

    // Queue the outputs expected right after the next rising edge.
    task automatic cyc(input string tag, input logic [14:0] e);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic run_frame(input string tag, input logic [23:0] snap, input logic [5:0] blk,
                             input logic [5:0] dpm, input bit d0_dark, input int chg_slot,
                             input logic [23:0] nd, input logic [5:0] nb, input logic [5:0] ndp);
        for (int s = 0; s < ND; s++) begin
            if (s == chg_slot) begin
                digits     = nd;
                blank_mask = nb;
                dp_mask    = ndp;
            end
            for (int c = 0; c < 4; c++) begin
                cyc(tag, exp_word(s, snap[4*s +: 4], blk[s] || (s == 0 && d0_dark), dpm[s],
                                  (s == ND - 1) && (c == 3)));
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        digits     = '0;
        blank_mask = '0;
        dp_mask    = '0;
        blink_mask = '0;

        #1 rst = 1'b0;
        #2 check("reset_state", {seg, dp, com, frame_done}, INACT);
        cyc("reset_hold", INACT);
        cyc("reset_hold", INACT);

        en     = 1'b1;
        digits = 24'h012345;
        rst    = 1'b1;
        cyc("en_first", INACT);
        run_frame("frame0", 24'h012345, 6'h00, 6'h00, 1'b0, -1, 24'h0, 6'h0, 6'h0);
        run_frame("frame1_change", 24'h012345, 6'h00, 6'h00, 1'b0, 2, 24'hFFFFFF, 6'h00, 6'h00);
        run_frame("frame2_all_f", 24'hFFFFFF, 6'h00, 6'h00, 1'b0, 0,
                  24'h012345, 6'b000100, 6'b000001);
        run_frame("frame3_blank_dp", 24'h012345, 6'b000100, 6'b000001, 1'b0, -1,
                  24'h0, 6'h0, 6'h0);

        // Drop en in the middle of slot 3: no frame_done, all outputs inactive.
        for (int k = 0; k < 14; k++) begin
            cyc("abort_partial", exp_word(k / 4, 4'(5 - k / 4), k / 4 == 2, k / 4 == 0, 1'b0));
        end
        en = 1'b0;
        cyc("en_off", INACT);
        cyc("en_off", INACT);
        cyc("en_off", INACT);
        en = 1'b1;
        cyc("en_on_first", INACT);
        run_frame("after_en", 24'h012345, 6'b000100, 6'b000001, 1'b0, -1, 24'h0, 6'h0, 6'h0);

        // Asynchronous reset between edges in slot 4, new digits waiting for the restart.
        digits = 24'h89ABCD;
        for (int k = 0; k < 18; k++) begin
            cyc("pre_reset", exp_word(k / 4, 4'(5 - k / 4), k / 4 == 2, k / 4 == 0, 1'b0));
        end
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check("reset_async_mid", {seg, dp, com, frame_done}, INACT);
        cyc("reset_hold2", INACT);
        rst = 1'b1;
        cyc("restart_first", INACT);
        run_frame("restart", 24'h89ABCD, 6'b000100, 6'b000001, 1'b0, -1, 24'h0, 6'h0, 6'h0);

        // Blink: digit 0 dark only for frames 32..63 when the feature is built in.
        en         = 1'b0;
        digits     = 24'h012345;
        blank_mask = '0;
        dp_mask    = '0;
        blink_mask = 6'b000001;
        cyc("blink_en_off", INACT);
        en = 1'b1;
        cyc("blink_first", INACT);
        for (int f = 0; f < 40; f++) begin
            run_frame("blink", 24'h012345, 6'h00, 6'h00, BLINK_ON && (f >= 32), -1,
                      24'h0, 6'h0, 6'h0);
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 15'(exp_q.size()), 15'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_gate.md
Name: seg7_scan_gate

Overview:
Parametrised multiplexed 7-segment scan driver with a global display-enable gate, per-digit blanking and frame-coherent digit snapshots. It replaces the fixed six-digit scanner and its per-output AND gating with one block. The block sits between the doorlock control logic, which supplies hex digit values and masks, and the board segment and common pins.

Parameters:
NUM_DIGITS, 6, number of scanned digits (1..8)
SCAN_DIV, 1000, clk cycles per digit slot (>=2)
SEG_ACT, 1, active level of seg/dp outputs (1 = high lights segment)
COM_ACT, 0, active level of com outputs (0 = low selects digit)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
en  input  1  display enable (gate); 0 forces all outputs inactive
digits  input  4*NUM_DIGITS  hex value per digit, digit i = bits [4i+3:4i]
blank_mask  input  NUM_DIGITS  1 = digit i dark (com still scans, seg inactive)
dp_mask  input  NUM_DIGITS  1 = decimal point lit on digit i
blink_mask  input  NUM_DIGITS  1 = digit i blinks (used only with BLINK_EN)
seg  output  7  segments {g,f,e,d,c,b,a}, bit0 = a
dp  output  1  decimal point
com  output  NUM_DIGITS  digit selects, com[0] = leftmost digit
frame_done  output  1  one-cycle pulse when the last digit slot ends

Behaviour:
- Reset (rst=0, asynchronous): prescaler=0, index=0, snapshot=0, seg/dp=~SEG_ACT, com all ~COM_ACT, frame_done=0.
- Prescaler counts 0..SCAN_DIV-1. At terminal count: index advances; NUM_DIGITS-1 wraps to 0. frame_done pulses on the same cycle the index wraps.
- Snapshot: digits, blank_mask and dp_mask are captured into internal registers when the index wraps to 0 and on the first enabled cycle. A digit value never changes mid-frame.
- Outputs are registered, with one cycle latency from index change to seg/com change. Exactly one com bit is active at a time.
- Decode is standard hex 0-F: 0=0x3F, 1=0x06, 8=0x7F, A=0x77, F=0x71 (active-high form). Output is inverted when SEG_ACT=0.
- Blanked digit: seg and dp are inactive during its slot; com still asserts, so scan timing is unchanged.
- en=0: on the next clock edge all seg/dp/com go inactive. Prescaler and index are held at 0. frame_done stays 0.
- en 0->1: snapshot is taken that cycle. Digit 0 is driven on the next cycle, and its slot lasts a full SCAN_DIV cycles.
- en deasserted mid-slot: scan aborts. No frame_done pulse for the partial frame.
- Async reset mid-frame: immediate return to the reset values. After release, behaviour matches en 0->1 if en=1.
- Invariant: com is all-inactive for exactly the cycle after en drops or reset. There are no glitch cycles with two digits selected.

Optional Feature:
BLINK_EN
- Defined: a blink counter increments on each frame_done. Its bit [BLINK_SHIFT=5] is the phase, and blink_mask is snapshotted with the other masks. While phase=1, digits with blink_mask=1 are treated as blanked. The blink counter resets with rst and clears when en=0.
- Undefined: blink_mask is ignored. There is no blink counter, and behaviour is identical to the BLINK_EN=1 case with blink_mask=0.

Test Plan:
- NUM_DIGITS=6, SCAN_DIV=4, en=1, digits=0x012345 -> com cycles 0..5, each active 4 cycles. seg on digit0 = 0x66 ("4" at bits[23:20]? no: digit0 = bits[3:0]=5 -> 0x6D). frame_done pulses every 24 cycles.
- Change digits from 0x012345 to 0xFFFFFF at slot 2 -> slots 3-5 still show 2,1,0 (0x5B,0x06,0x3F). The next frame shows 0x71 on all digits.
- blank_mask=6'b000100, dp_mask=6'b000001 -> in slot 2 seg=0x00 with com[2] active. In slot 0, dp=1.
- en 1->0 during slot 3 -> next cycle seg=0, dp=0, com=6'b111111 (COM_ACT=0), with no frame_done. en 0->1 -> digit 0 is shown one cycle later for 4 cycles.
- rst pulsed low mid-slot 4 (asynchronous, between edges) -> outputs inactive immediately. After release, the scan restarts at digit 0.
- BLINK_EN defined, blink_mask=6'b000001 -> digit 0 is dark for frames 32-63 and lit for frames 0-31. Other digits are never dark.
